// File: rtl/reg8_write_arbiter_if.sv
// Bus bundle between the requesters/register and the write arbiter.
// The arbiter sits on the slave side; requesters (or a bench) use master.
interface reg8_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] wr_data;
  logic                 clr_req;
  logic                 preset_req;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   ack;
  logic                 clr_done;
  logic                 preset_done;
  logic                 busy;
  // register side
  logic [7:0]           reg_d;
  logic                 reg_wr_en;
  logic                 reg_rst;
  logic                 reg_set;

  modport slave (
    input  req, wr_data, clr_req, preset_req,
    output grant, ack, clr_done, preset_done, busy,
    output reg_d, reg_wr_en, reg_rst, reg_set
  );

  modport master (
    output req, wr_data, clr_req, preset_req,
    input  grant, ack, clr_done, preset_done, busy,
    input  reg_d, reg_wr_en, reg_rst, reg_set
  );
endinterface

// File: rtl/reg8_write_arbiter.sv
// Round-robin write controller for a shared 8-bit D/Rst/set register.
// Clear beats preset beats data writes; a started write always finishes.
// Every output is a flop computed from the next state, so outputs line up
// with the state the FSM is in during that cycle.
module reg8_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                Rst,
  reg8_write_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, PRESET, SETUP, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;
  logic               rst_p_q, rst_p_d;
  logic               set_p_q, set_p_d;
  logic               clr_done_q, clr_done_d;
  logic               pre_done_q, pre_done_d;

  logic               found;
  logic [IW-1:0]      pick;
  int                 idx;

  // round-robin search: first asserted req at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // next state, latched winner/data, setup counter, rotation pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req)           state_d = CLEAR;
        else if (bus.preset_req)   state_d = PRESET;
        else if (found) begin
          win_d  = pick;
          data_d = bus.wr_data[int'(pick)*8 +: 8];
          if (SETUP_CYCLES == 0) begin
            state_d = WRITE;
          end else begin
            state_d = SETUP;
            cnt_d   = 4'd1;
          end
        end
      end
      CLEAR:  state_d = IDLE;
      PRESET: state_d = IDLE;
      SETUP: begin
        if (int'(cnt_q) >= SETUP_CYCLES) begin
          state_d = WRITE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE:  state_d = DONE;
      DONE: begin
        state_d = IDLE;
        ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // registered outputs decoded from the state being entered
  always_comb begin
    grant_d    = '0;
    ack_d      = '0;
    busy_d     = (state_d != IDLE);
    wr_en_d    = (state_d == WRITE);
    rst_p_d    = (state_d == CLEAR);
    set_p_d    = (state_d == PRESET);
    clr_done_d = (state_d == CLEAR);
    pre_done_d = (state_d == PRESET);
    if (state_d == SETUP || state_d == WRITE || state_d == DONE)
      grant_d[win_d] = 1'b1;
    if (state_d == DONE)
      ack_d[win_d] = 1'b1;
  end

  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rst_p_q    <= 1'b0;
      set_p_q    <= 1'b0;
      clr_done_q <= 1'b0;
      pre_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rst_p_q    <= rst_p_d;
      set_p_q    <= set_p_d;
      clr_done_q <= clr_done_d;
      pre_done_q <= pre_done_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.reg_d       = data_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rst     = rst_p_q;
  assign bus.reg_set     = set_p_q;
  assign bus.clr_done    = clr_done_q;
  assign bus.preset_done = pre_done_q;
endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Directed bench for reg8_write_arbiter (NUM_REQ=4, SETUP_CYCLES=1).
// Expected writes are queued when a request is driven; a negedge monitor
// pops them on each reg_wr_en and checks data, grant and the ack that follows.
module tb_reg8_write_arbiter;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   nchk = 0;
  int   npass = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic       ack_pend = 1'b0;
  int         pend_idx = 0;
  logic [7:0] q_reg = 8'h00;

  reg8_write_arbiter_if #(.NUM_REQ(4)) bus ();

  reg8_write_arbiter #(.NUM_REQ(4), .SETUP_CYCLES(1)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // returns at the negedge where one of the masked ack bits is high
  task automatic wait_ack(input logic [3:0] m, input string tag);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((bus.ack & m) == 4'h0 && n < 40);
    check(tag, 32'(|(bus.ack & m)), 32'd1);
  endtask

  // scoreboard / register model / per-cycle invariants
  always @(negedge Clk) begin
    if (Rst) begin
      ack_pend = 1'b0;
    end else begin
      check("grant onehot0", 32'($onehot0(bus.grant)), 32'd1);
      check("strobe excl", 32'($countones({bus.reg_wr_en, bus.reg_rst, bus.reg_set}) <= 1), 32'd1);
      check("ack", 32'(bus.ack), ack_pend ? (32'd1 << pend_idx) : 32'd0);
      ack_pend = 1'b0;
      if (bus.reg_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected write", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write data", 32'(bus.reg_d), 32'(e.data));
          check("write grant", 32'(bus.grant), 32'd1 << e.idx);
          ack_pend = 1'b1;
          pend_idx = e.idx;
        end
        q_reg = bus.reg_d;
      end
      if (bus.reg_rst) q_reg = 8'h00;
      if (bus.reg_set) q_reg = 8'hFF;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req = '0; bus.wr_data = '0; bus.clr_req = 1'b0; bus.preset_req = 1'b0;

    // 1: reset state, then two quiet idle cycles
    tick(); tick();
    check("rst busy", 32'(bus.busy), 0);
    check("rst grant", 32'(bus.grant), 0);
    Rst = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      check("idle outs", 32'({bus.grant, bus.ack, bus.busy, bus.reg_wr_en, bus.reg_rst,
                              bus.reg_set, bus.clr_done, bus.preset_done}), 0);
      check("idle reg_d", 32'(bus.reg_d), 0);
    end

    // 2: single write from requester 0
    tick();
    bus.req = 4'b0001; bus.wr_data[7:0] = 8'hA5; push(0, 8'hA5);
    tick();
    @(negedge Clk);
    check("t2 grant", 32'(bus.grant), 32'b0001);
    check("t2 reg_d", 32'(bus.reg_d), 32'hA5);
    check("t2 wr_en setup", 32'(bus.reg_wr_en), 0);
    check("t2 busy", 32'(bus.busy), 1);
    @(negedge Clk);
    check("t2 wr_en", 32'(bus.reg_wr_en), 1);
    wait_ack(4'b0001, "t2 ack");
    // ptr is now 1: with req 0 and 1 both up, requester 1 wins first
    bus.req = 4'b0011; bus.wr_data[15:0] = 16'hB1B0;
    push(1, 8'hB1); push(0, 8'hB0);
    check("t2 Q", 32'(q_reg), 32'hA5);
    wait_ack(4'b0010, "t2 ack1");
    bus.req = 4'b0001;
    wait_ack(4'b0001, "t2 ack0");
    bus.req = 4'b0000;

    // 3: reset ptr, then all four held -> 10,11,12,13,10
    tick();
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    bus.wr_data = 32'h13121110;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack(4'b1111, "t3 ack");
    bus.req = 4'b0000;
    check("t3 drained", 32'(exp_q.size()), 0);

    // 4: Q=3C, then clear and req 2 together -> clear first
    tick();
    bus.req = 4'b1000; bus.wr_data[31:24] = 8'h3C; push(3, 8'h3C);
    wait_ack(4'b1000, "t4 ack3");
    bus.req = 4'b0100; bus.clr_req = 1'b1; bus.wr_data[23:16] = 8'h5A; push(2, 8'h5A);
    check("t4 Q pre", 32'(q_reg), 32'h3C);
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus.clr_done && n < 20);
    check("t4 clr_done", 32'(bus.clr_done), 1);
    check("t4 reg_rst", 32'(bus.reg_rst), 1);
    check("t4 no grant", 32'(bus.grant), 0);
    check("t4 write pending", 32'(exp_q.size()), 1);
    bus.clr_req = 1'b0;
    @(negedge Clk);
    check("t4 Q clr", 32'(q_reg), 0);
    check("t4 rst pulse", 32'(bus.reg_rst), 0);
    wait_ack(4'b0100, "t4 ack2");
    bus.req = 4'b0000;
    check("t4 Q wr", 32'(q_reg), 32'h5A);

    // 5: preset raised during WRITE of requester 1
    tick();
    bus.req = 4'b0010; bus.wr_data[15:8] = 8'h77; push(1, 8'h77);
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus.reg_wr_en && n < 20);
    check("t5 wr_en", 32'(bus.reg_wr_en), 1);
    bus.preset_req = 1'b1;
    wait_ack(4'b0010, "t5 ack1");
    check("t5 no set yet", 32'(bus.reg_set), 0);
    bus.req = 4'b0000;
    n = 0;
    do begin @(negedge Clk); n++; end while (!bus.preset_done && n < 20);
    check("t5 preset_done", 32'(bus.preset_done), 1);
    check("t5 reg_set", 32'(bus.reg_set), 1);
    bus.preset_req = 1'b0;
    @(negedge Clk);
    check("t5 Q", 32'(q_reg), 32'hFF);
    check("t5 set pulse", 32'(bus.reg_set), 0);

    // 6: reset during SETUP, then rotation restarts from 0
    tick();
    bus.req = 4'b0001; bus.wr_data[7:0] = 8'h99; push(0, 8'h99);
    n = 0;
    do begin @(negedge Clk); n++; end while (bus.grant == 4'h0 && n < 20);
    check("t6 grant", 32'(bus.grant), 32'b0001);
    check("t6 setup no wr", 32'(bus.reg_wr_en), 0);
    Rst = 1'b1;
    #1;
    check("t6 async outs", 32'({bus.grant, bus.ack, bus.busy, bus.reg_wr_en}), 0);
    check("t6 async reg_d", 32'(bus.reg_d), 0);
    exp_q.delete();
    bus.req = 4'b0000;
    tick(); tick();
    Rst = 1'b0;
    bus.wr_data = 32'hE3_00_E1_00;
    bus.req = 4'b1010;
    push(1, 8'hE1); push(3, 8'hE3);
    wait_ack(4'b0010, "t6 ack1");
    bus.req = 4'b1000;
    wait_ack(4'b1000, "t6 ack3");
    bus.req = 4'b0000;
    repeat (3) @(negedge Clk);
    check("t6 idle busy", 32'(bus.busy), 0);
    check("t6 drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
